pet_stat_engine: RTL and testbench
==================================

PET_STAT_ENGINE -- requirements
Module: pet_stat_engine

Interface
REQ-001 Parameter NUM_STATS, default 6: number of stat channels, 2..8.
REQ-002 Parameter STAT_W, default 5: width of each stat.
REQ-003 Parameter STAT_MAX, default 15: saturation and critical level, at most 2^STAT_W-1.
REQ-004 Parameter TICK_DIV, default 27000000: clk cycles per tick, at least 2.
REQ-005 Parameter SLEEP_DECAY, default 2: ticks per energy decrement while sleeping, at least 1.
REQ-006 Parameter ENERGY_IDX, default 4: channel restored by sleep.
REQ-007 Parameter CMD_CODES, default {8'h74,8'h00,8'h62,8'h64,8'h70,8'h65} (index NUM_STATS-1..0): per-channel care command byte; 8'h00 means no command for that channel.
REQ-008 Parameters CMD_SLEEP, CMD_WAKE, CMD_REVIVE, defaults 8'h73, 8'h77, 8'h72: mode command bytes.
REQ-009 Clock is clk; reset is reset, asynchronous, active-high.
REQ-010 Port clk, input, 1 bit: system clock.
REQ-011 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-012 Port cmd, input, 8 bits: command byte, level-held; 8'h00 means idle.
REQ-013 Port random, input, 8 bits: random value, sampled on tick.
REQ-014 Port stats, output, NUM_STATS*STAT_W bits: packed stats; channel k is at [k*STAT_W +: STAT_W].
REQ-015 Port mode, output, 2 bits: 0 AWAKE, 1 SLEEPING, 2 CRITICAL.
REQ-016 Port tick, output, 1 bit: one-cycle pulse per tick.
REQ-017 Port second, output, 1 bit: toggles on every tick.
REQ-018 Port crit_ticks, output, 8 bits: ticks spent in CRITICAL, saturating at 255.

Function
REQ-019 The divider SHALL count 0..TICK_DIV-1, assert tick in the cycle where count = TICK_DIV-1, and wrap to 0.
REQ-020 On tick, sel = random mod 8; if sel < NUM_STATS, channel sel SHALL increment by 1, saturating at STAT_MAX.
REQ-021 Exceptions to REQ-020:
- No tick increment of any stat in CRITICAL.
- No tick increment of ENERGY_IDX in SLEEPING.
REQ-022 In SLEEPING, a sleep counter SHALL count ticks; every SLEEP_DECAY-th tick, ENERGY_IDX SHALL decrement by 1, floored at 0.
REQ-023 The sleep counter SHALL be cleared on entry to SLEEPING.
REQ-024 Command acceptance SHALL be one-shot through an armed flag:
- A non-zero cmd is accepted only while armed; acceptance clears armed.
- cmd = 8'h00 sets armed.
- A non-zero cmd that is ignored leaves armed unchanged.
REQ-025 In AWAKE, accepted cmd equal to a non-zero CMD_CODES[k] SHALL decrement channel k by 1, floored at 0.
REQ-026 If the same channel gets a tick increment and a command decrement in the same cycle, its value SHALL stay unchanged.
REQ-027 Events on different channels in the same cycle SHALL each take effect.
REQ-028 In AWAKE, accepted CMD_SLEEP SHALL move mode to SLEEPING on the next cycle.
REQ-029 In SLEEPING, accepted CMD_WAKE SHALL move mode to AWAKE; all other commands are ignored but still consumed (armed cleared).
REQ-030 In SLEEPING, ENERGY_IDX reaching 0 SHALL move mode to AWAKE on the following cycle.
REQ-031 CRITICAL entry: in any mode, if any registered stat equals STAT_MAX, mode SHALL become CRITICAL on the next cycle.
- This has priority over all other transitions.
- It also applies when the same-cycle command was consumed.
REQ-032 In CRITICAL, accepted CMD_REVIVE SHALL do all of the following in the next cycle:
- clear all stats to 0;
- clear crit_ticks;
- set mode to AWAKE.
REQ-033 In CRITICAL, all commands other than CMD_REVIVE SHALL be ignored.
REQ-034 crit_ticks SHALL increment on each tick while mode = CRITICAL, saturating at 255.
REQ-035 All outputs SHALL be registered; stats and mode reflect events one cycle after the causing edge.

Reset
REQ-036 While reset is high, the following SHALL hold asynchronously:
- all stats = 0, mode = AWAKE;
- divider = 0, tick = 0, second = 0;
- crit_ticks = 0, sleep counter = 0, armed = 1.
REQ-037 Counting SHALL resume from 0 on the first clk edge after reset deasserts.
REQ-038 Reset asserted mid-tick or mid-sleep SHALL discard all pending state.

Verification
REQ-039 Tick/increment: TICK_DIV=4, random=8'h01 -> tick every 4 cycles, channel 1 increments each tick, saturates at 15.
REQ-040 Next-cycle CRITICAL: channel 1 reaches 15 -> mode=2 next cycle; crit_ticks counts ticks; cmd 8'h65 ignored.
REQ-041 CRITICAL and revive: in CRITICAL, cmd 8'h72 -> all stats 0, mode=0, crit_ticks=0.
REQ-042 One-shot: cmd 8'h65 held 10 cycles with channel 0=5 -> channel 0=4 only; after cmd=00 then 65 -> channel 0=3.
REQ-043 Sleep decay and auto-wake: energy=3, cmd 8'h73 -> mode=1; energy drops 1 per 2 ticks; energy=0 -> mode=0 next cycle.
REQ-044 Collision: random=8'h00 tick coinciding with accepted 8'h65 on channel 0=7 -> channel 0 stays 7.
REQ-045 Reset mid-operation: reset asserted in SLEEPING mid-count -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pet_stat_engine.sv
// rtl/pet_stat_engine.sv - virtual pet stat engine: tick divider, stat channels, care commands, mode FSM
// Stats drift up on random ticks; care commands pull them back; any stat at max forces CRITICAL.
module pet_stat_engine #(
  parameter int                     NUM_STATS   = 6,
  parameter int                     STAT_W      = 5,
  parameter int                     STAT_MAX    = 15,
  parameter int                     TICK_DIV    = 27000000,
  parameter int                     SLEEP_DECAY = 2,
  parameter int                     ENERGY_IDX  = 4,
  parameter logic [NUM_STATS*8-1:0] CMD_CODES   = {8'h74, 8'h00, 8'h62, 8'h64, 8'h70, 8'h65},
  parameter logic [7:0]             CMD_SLEEP   = 8'h73,
  parameter logic [7:0]             CMD_WAKE    = 8'h77,
  parameter logic [7:0]             CMD_REVIVE  = 8'h72
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    cmd,
  input  logic [7:0]                    random,
  output logic [NUM_STATS*STAT_W-1:0]   stats,
  output logic [1:0]                    mode,
  output logic                          tick,
  output logic                          second,
  output logic [7:0]                    crit_ticks
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int SLP_W = (SLEEP_DECAY > 1) ? $clog2(SLEEP_DECAY) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SLP_W-1:0]  SLP_LAST = SLP_W'(SLEEP_DECAY - 1);
  localparam logic [STAT_W-1:0] S_MAX    = STAT_W'(STAT_MAX);

  typedef enum logic [1:0] {
    ST_AWAKE = 2'd0,
    ST_SLEEP = 2'd1,
    ST_CRIT  = 2'd2
  } mode_t;

  mode_t              r_mode;
  mode_t              w_mode_nxt;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   w_div_nxt;
  logic               r_tick;
  logic               r_second;
  logic [7:0]         r_crit;
  logic [SLP_W-1:0]   r_slp_cnt;
  logic               r_armed;
  logic [STAT_W-1:0]  r_stat     [NUM_STATS];
  logic [STAT_W-1:0]  w_stat_nxt [NUM_STATS];
  logic               w_inc      [NUM_STATS];
  logic               w_dec      [NUM_STATS];
  logic [2:0]         w_sel;
  logic               w_cmd_nz;
  logic               w_accept;
  logic               w_revive;
  logic               w_sleep_hit;
  logic               w_any_max;
  logic [STAT_W-1:0]  w_energy;
  logic               w_unused_random;

  assign w_sel           = random[2:0];
  assign w_unused_random = ^random[7:3];
  assign w_energy        = r_stat[ENERGY_IDX];

  // r_tick is high exactly while the divider sits at its last count
  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_tick   <= 1'b0;
      r_second <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_tick <= (w_div_nxt == DIV_LAST);
      if (r_tick) r_second <= ~r_second;
    end
  end

  // In CRITICAL only revive may consume the armed flag
  assign w_cmd_nz = |cmd;
  assign w_accept = r_armed && w_cmd_nz && !(r_mode == ST_CRIT && cmd != CMD_REVIVE);
  assign w_revive = w_accept && (r_mode == ST_CRIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_armed <= 1'b1;
    else if (!w_cmd_nz) r_armed <= 1'b1;
    else if (w_accept)  r_armed <= 1'b0;
  end

  assign w_sleep_hit = r_tick && (r_mode == ST_SLEEP) && (r_slp_cnt == SLP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_slp_cnt <= '0;
    else if (r_mode != ST_SLEEP) r_slp_cnt <= '0;
    else if (r_tick)             r_slp_cnt <= (r_slp_cnt == SLP_LAST) ? '0 : r_slp_cnt + SLP_W'(1);
  end

  always_comb begin
    w_any_max = 1'b0;
    for (int k = 0; k < NUM_STATS; k++) begin
      if (r_stat[k] == S_MAX) w_any_max = 1'b1;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      ST_AWAKE: if (w_accept && cmd == CMD_SLEEP) w_mode_nxt = ST_SLEEP;
      ST_SLEEP: if ((w_accept && cmd == CMD_WAKE) || w_energy == '0) w_mode_nxt = ST_AWAKE;
      ST_CRIT:  if (w_revive) w_mode_nxt = ST_AWAKE;
      default:  w_mode_nxt = ST_AWAKE;
    endcase
    if (w_any_max && !w_revive) w_mode_nxt = ST_CRIT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mode <= ST_AWAKE;
    else       r_mode <= w_mode_nxt;
  end

  // An increment and a decrement landing on one channel cancel out
  always_comb begin
    for (int k = 0; k < NUM_STATS; k++) begin
      w_inc[k] = r_tick && (w_sel == 3'(k)) &&
                 (r_mode == ST_AWAKE || (r_mode == ST_SLEEP && k != ENERGY_IDX));
      w_dec[k] = (w_accept && r_mode == ST_AWAKE && CMD_CODES[k*8 +: 8] != 8'h00 &&
                  cmd == CMD_CODES[k*8 +: 8]) ||
                 (k == ENERGY_IDX && w_sleep_hit);
      w_stat_nxt[k] = r_stat[k];
      if (w_revive) begin
        w_stat_nxt[k] = '0;
      end else if (w_inc[k] && !w_dec[k]) begin
        if (r_stat[k] < S_MAX) w_stat_nxt[k] = r_stat[k] + STAT_W'(1);
      end else if (w_dec[k] && !w_inc[k]) begin
        if (r_stat[k] != '0) w_stat_nxt[k] = r_stat[k] - STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STATS; k++) r_stat[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_STATS; k++) r_stat[k] <= w_stat_nxt[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                               r_crit <= 8'd0;
    else if (w_revive)                                       r_crit <= 8'd0;
    else if (r_mode == ST_CRIT && r_tick && r_crit != 8'hFF) r_crit <= r_crit + 8'd1;
  end

  for (genvar g = 0; g < NUM_STATS; g++) begin : g_pack
    assign stats[g*STAT_W +: STAT_W] = r_stat[g];
  end

  assign mode       = r_mode;
  assign tick       = r_tick;
  assign second     = r_second;
  assign crit_ticks = r_crit;

endmodule

// File: tb/tb_pet_stat_engine.sv
// tb/tb_pet_stat_engine.sv - directed scoreboard bench for pet_stat_engine with TICK_DIV=4
module tb_pet_stat_engine;

  logic        clk;
  logic        reset;
  logic [7:0]  cmd;
  logic [7:0]  random;
  logic [29:0] stats;
  logic [1:0]  mode;
  logic        tick;
  logic        second;
  logic [7:0]  crit_ticks;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];

  pet_stat_engine #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .random     (random),
    .stats      (stats),
    .mode       (mode),
    .tick       (tick),
    .second     (second),
    .crit_ticks (crit_ticks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] st(input int k);
    return 32'(stats[k*5 +: 5]);
  endfunction

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %0d expected a queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === 32'(e.val)) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wait_tick_hi();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL tick_timeout observed no tick expected tick within 20 cycles");
    end
  endtask

  task automatic next_tick();
    wait_tick_hi();
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    cmd    = 8'h00;
    random = 8'h00;
    repeat (3) @(negedge clk);
    push("rst_stats", 0);  pop_check(32'(stats));
    push("rst_mode", 0);   pop_check(32'(mode));
    push("rst_tick", 0);   pop_check(32'(tick));
    push("rst_second", 0); pop_check(32'(second));
    push("rst_crit", 0);   pop_check(32'(crit_ticks));

    reset = 1'b0;
    push("div_tick_lo", 0);
    repeat (2) @(negedge clk);
    pop_check(32'(tick));
    push("div_tick_hi", 1);
    @(negedge clk);
    pop_check(32'(tick));
    push("tick_inc_ch0", 1);
    push("tick_pulse_end", 0);
    push("second_toggle", 1);
    @(negedge clk);
    pop_check(st(0));
    pop_check(32'(tick));
    pop_check(32'(second));

    random = 8'h08;
    push("sel_mod8_ch0", 2);
    next_tick();
    pop_check(st(0));

    random = 8'h06;
    push("sel_out_of_range", 2);
    next_tick();
    pop_check(32'(stats));

    random = 8'h01;
    push("ch1_at_14", 14);
    push("mode_awake_14", 0);
    repeat (14) next_tick();
    pop_check(st(1));
    pop_check(32'(mode));
    push("ch1_at_max", 15);
    push("mode_lag", 0);
    push("second_even", 0);
    next_tick();
    pop_check(st(1));
    pop_check(32'(mode));
    pop_check(32'(second));
    push("mode_crit", 2);
    @(negedge clk);
    pop_check(32'(mode));

    cmd = 8'h65;
    push("crit_ignore_ch0", 2);
    push("crit_no_inc_ch1", 15);
    push("crit_ticks_2", 2);
    push("crit_mode_hold", 2);
    repeat (2) next_tick();
    pop_check(st(0));
    pop_check(st(1));
    pop_check(32'(crit_ticks));
    pop_check(32'(mode));

    cmd    = 8'h00;
    random = 8'h07;
    @(negedge clk);
    cmd = 8'h72;
    push("revive_stats", 0);
    push("revive_mode", 0);
    push("revive_crit", 0);
    @(negedge clk);
    pop_check(32'(stats));
    pop_check(32'(mode));
    pop_check(32'(crit_ticks));
    cmd = 8'h00;

    random = 8'h00;
    push("build_ch0_5", 5);
    repeat (5) next_tick();
    pop_check(st(0));
    random = 8'h07;
    cmd    = 8'h65;
    push("oneshot_held", 4);
    repeat (10) @(negedge clk);
    pop_check(st(0));
    cmd = 8'h00;
    @(negedge clk);
    cmd = 8'h65;
    push("oneshot_rearm", 3);
    @(negedge clk);
    pop_check(st(0));
    cmd = 8'h00;
    @(negedge clk);

    random = 8'h01;
    wait_tick_hi();
    cmd = 8'h65;
    push("multi_ch0_dec", 2);
    push("multi_ch1_inc", 1);
    @(negedge clk);
    pop_check(st(0));
    pop_check(st(1));
    cmd = 8'h00;
    @(negedge clk);

    random = 8'h00;
    push("build_ch0_7", 7);
    repeat (5) next_tick();
    pop_check(st(0));
    wait_tick_hi();
    cmd = 8'h65;
    push("collide_ch0", 7);
    @(negedge clk);
    pop_check(st(0));
    cmd    = 8'h00;
    random = 8'h07;
    @(negedge clk);

    random = 8'h04;
    push("build_energy_3", 3);
    repeat (3) next_tick();
    pop_check(st(4));
    random = 8'h07;
    cmd    = 8'h73;
    push("sleep_enter", 1);
    @(negedge clk);
    pop_check(32'(mode));
    cmd    = 8'h00;
    random = 8'h04;
    push("sleep_t1_energy", 3);
    next_tick();
    pop_check(st(4));
    push("sleep_t2_energy", 2);
    next_tick();
    pop_check(st(4));
    push("sleep_t4_energy", 1);
    repeat (2) next_tick();
    pop_check(st(4));
    push("sleep_t6_energy", 0);
    push("sleep_t6_mode", 1);
    next_tick();
    next_tick();
    pop_check(st(4));
    pop_check(32'(mode));
    random = 8'h07;
    push("auto_wake", 0);
    push("sleep_ch0_kept", 7);
    @(negedge clk);
    pop_check(32'(mode));
    pop_check(st(0));

    random = 8'h04;
    repeat (3) next_tick();
    random = 8'h07;
    cmd    = 8'h73;
    @(negedge clk);
    cmd = 8'h65;
    push("sleep_care_ignored", 7);
    push("sleep_care_mode", 1);
    repeat (2) @(negedge clk);
    pop_check(st(0));
    pop_check(32'(mode));
    cmd = 8'h77;
    push("wake_unarmed", 1);
    repeat (2) @(negedge clk);
    pop_check(32'(mode));
    cmd = 8'h00;
    @(negedge clk);
    cmd = 8'h77;
    push("wake_cmd", 0);
    @(negedge clk);
    pop_check(32'(mode));
    cmd = 8'h00;
    @(negedge clk);

    cmd = 8'h73;
    push("sleep_again", 1);
    @(negedge clk);
    pop_check(32'(mode));
    cmd = 8'h00;
    next_tick();
    #2 reset = 1'b1;
    push("async_rst_stats", 0);
    push("async_rst_mode", 0);
    push("async_rst_tick", 0);
    push("async_rst_second", 0);
    push("async_rst_crit", 0);
    #1;
    pop_check(32'(stats));
    pop_check(32'(mode));
    pop_check(32'(tick));
    pop_check(32'(second));
    pop_check(32'(crit_ticks));
    @(negedge clk);
    reset = 1'b0;
    push("resume_tick_lo", 0);
    repeat (2) @(negedge clk);
    pop_check(32'(tick));
    push("resume_tick_hi", 1);
    @(negedge clk);
    pop_check(32'(tick));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
